// File: rtl/paralelo_serial_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
//   state_t           : transmitter sequencing states
//   IDLE_WORD_DEFAULT : idle/training symbol for the default 8-bit build
//   clog2             : ceil(log2(value)), never less than 1 (safe as a vector width)
package paralelo_serial_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hBC;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/fifo_paralelo.sv
// Synchronous FIFO, WIDTH x DEPTH (DEPTH a power of 2), no fall-through.
// Ports:
//   clk_32f  in   clock, posedge
//   reset    in   synchronous active-high, clears pointers and count
//   push     in   write wr_data (caller guarantees not full)
//   pop      in   advance head (caller guarantees not empty)
//   wr_data  in   WIDTH word to write
//   rd_data  out  current head word
//   count    out  occupancy 0..DEPTH
module fifo_paralelo
  import paralelo_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_32f) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial transmitter: queues WIDTH-bit words and shifts them out one
// bit per clock, sending MIN_IDLE training idle words after reset and IDLE_WORD
// whenever the queue runs dry.
// Ports:
//   clk_32f       in   bit clock, posedge
//   reset         in   synchronous active-high
//   valid_in      in   data_in valid
//   data_in       in   parallel word
//   ready_out     out  queue can accept a word
//   data_out      out  serial bit
//   word_start    out  first bit of every word
//   sending_data  out  all bits of a queued (non-idle) word
//   fifo_count    out  queue occupancy
//
// state | meaning
// RST   | held in reset; outputs quiet, queue closed
// TRAIN | sending MIN_IDLE training idle words; queue accepts but is not drained
// RUN   | sending queued words, IDLE_WORD when empty
module paralelo_serial_param
  import paralelo_serial_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_WORD_DEFAULT),
  parameter int             MIN_IDLE  = 2,
  parameter bit             MSB_FIRST = 1'b1,
  localparam int            CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             word_start,
  output logic             sending_data,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int BIT_W  = clog2(WIDTH);
  localparam int IDLE_W = clog2(MIN_IDLE + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(MIN_IDLE - 1);

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_left, idle_left_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  shift_reg;
  logic [WIDTH-1:0]  fifo_head;
  logic [WIDTH-1:0]  load_word;
  logic              is_data;
  logic              load, load_data, take_fifo, pop, push, word_end;

  assign ready_out = (state != RST) && (fifo_count < CNT_W'(DEPTH));
  assign push      = valid_in && ready_out;
  assign word_end  = (bit_cnt == LAST_BIT);

  fifo_paralelo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_32f (clk_32f),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= RST;
      idle_left <= '0;
    end else begin
      state     <= state_nxt;
      idle_left <= idle_left_nxt;
    end
  end

  // idle_left is a down-counter of training words still to finish; at zero the
  // boundary edge already follows RUN rules so data can follow training directly.
  always_comb begin
    state_nxt     = state;
    idle_left_nxt = idle_left;
    load          = 1'b0;
    take_fifo     = 1'b0;
    pop           = 1'b0;
    load_data     = 1'b0;
    load_word     = IDLE_WORD;
    case (state)
      RST: begin
        state_nxt     = TRAIN;
        idle_left_nxt = IDLE_LAST;
        load          = 1'b1;
      end
      TRAIN: begin
        if (word_end) begin
          load = 1'b1;
          if (idle_left == '0) begin
            state_nxt = RUN;
            take_fifo = 1'b1;
          end else begin
            idle_left_nxt = idle_left - 1'b1;
          end
        end
      end
      RUN: begin
        if (word_end) begin
          load      = 1'b1;
          take_fifo = 1'b1;
        end
      end
      default: state_nxt = RST;
    endcase
    if (take_fifo && (fifo_count != '0)) begin
      pop       = 1'b1;
      load_data = 1'b1;
      load_word = fifo_head;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      is_data   <= 1'b0;
    end else if (load) begin
      bit_cnt   <= '0;
      shift_reg <= load_word;
      is_data   <= load_data;
    end else begin
      bit_cnt   <= bit_cnt + 1'b1;
      shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

  assign data_out     = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
  assign word_start   = (bit_cnt == '0) && (state != RST);
  assign sending_data = is_data;

endmodule

// File: tb/tb_paralelo_serial_param.sv
module tb_paralelo_serial_param;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int MINI = 2;
  localparam logic [7:0] IDLE = 8'hBC;

  logic clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic       reset, valid_in;
  logic [7:0] data_in;
  logic       ready_out, data_out, word_start, sending_data;
  logic [2:0] fifo_count;

  logic       rst10, valid10;
  logic [9:0] data10;
  logic       ready10, dout10, ws10, sd10;
  logic [2:0] cnt10;

  paralelo_serial_param dut (
    .clk_32f(clk_32f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .data_out(data_out), .word_start(word_start),
    .sending_data(sending_data), .fifo_count(fifo_count)
  );

  paralelo_serial_param #(.WIDTH(10), .IDLE_WORD(10'h17C), .MSB_FIRST(1'b0)) dut10 (
    .clk_32f(clk_32f), .reset(rst10), .valid_in(valid10), .data_in(data10),
    .ready_out(ready10), .data_out(dout10), .word_start(ws10),
    .sending_data(sd10), .fifo_count(cnt10)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time since release decides training vs run; a queue holds words.
  bit         m_rel = 1'b0;
  int         m_t = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_cur = '0;
  bit         m_dat = 1'b0;

  logic [7:0] cap;
  int         cap_n = 0;
  logic [7:0] dut_words[$];
  int         peak = 0;

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    bit   pre_ready;
    int   b;
    logic e_do, e_ws, e_sd, e_rdy;
    int   e_cnt;
    reset = r; valid_in = v; data_in = d;
    pre_ready = m_rel && (m_q.size() < D);
    @(posedge clk_32f);
    if (r) begin
      m_rel = 1'b0; m_q.delete(); m_cur = '0; m_dat = 1'b0;
    end else if (!m_rel) begin
      m_rel = 1'b1; m_t = 0; m_cur = IDLE; m_dat = 1'b0;
    end else begin
      m_t++;
      if (m_t % W == 0) begin
        if ((m_t / W) < MINI || m_q.size() == 0) begin
          m_cur = IDLE; m_dat = 1'b0;
        end else begin
          m_cur = m_q.pop_front(); m_dat = 1'b1;
        end
      end
    end
    if (!r && pre_ready && v) m_q.push_back(d);
    @(negedge clk_32f);
    if (!m_rel) begin
      e_do = 0; e_ws = 0; e_sd = 0; e_rdy = 0; e_cnt = 0;
    end else begin
      b = m_t % W;
      e_do = m_cur[W-1-b]; e_ws = (b == 0); e_sd = m_dat;
      e_cnt = m_q.size(); e_rdy = (m_q.size() < D);
    end
    check_eq("data_out",     32'(data_out),     32'(e_do));
    check_eq("word_start",   32'(word_start),   32'(e_ws));
    check_eq("sending_data", 32'(sending_data), 32'(e_sd));
    check_eq("fifo_count",   32'(fifo_count),   32'(e_cnt));
    check_eq("ready_out",    32'(ready_out),    32'(e_rdy));
    if (32'(fifo_count) > 32'(peak)) peak = int'(fifo_count);
    if (r) cap_n = 0;
    else if (sending_data) begin
      if (word_start) begin cap_n = 0; cap = '0; end
      cap = {cap[6:0], data_out};
      cap_n++;
      if (cap_n == W) dut_words.push_back(cap);
    end
  endtask

  task automatic restart();
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    dut_words.delete();
    peak = 0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_words(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_n"}, 32'(dut_words.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_words.size(); i++)
      check_eq(tag, 32'(dut_words[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_w[$];
    logic [7:0] src[$];
    int         idx, guard;
    bit         saw_full, found, pend;
    logic [7:0] pdata;
    logic       rdy_now, r;
    logic [9:0] idle10;
    int         t6_bits[10];

    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    rst10 = 1'b1; valid10 = 1'b0; data10 = '0;
    @(negedge clk_32f);

    // 1: reset then idle stream
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
    check_eq("t1_rst_count", 32'(fifo_count), 32'd0);
    tick(1'b0, 1'b0, 8'h00);
    idle_ticks(24);
    check_eq("t1_no_data", 32'(dut_words.size()), 32'd0);

    // 2: push during first idle word
    restart();
    tick(1'b0, 1'b1, 8'hFF);
    tick(1'b0, 1'b1, 8'hEE);
    tick(1'b0, 1'b1, 8'hDD);
    idle_ticks(50);
    exp_w = '{8'hFF, 8'hEE, 8'hDD};
    check_words("t2_word", exp_w);
    check_eq("t2_peak", 32'(peak), 32'd3);

    // 3: six words offered back to back; source holds while not ready
    restart();
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0; guard = 0; saw_full = 1'b0;
    while (idx < 6 && guard < 200) begin
      rdy_now = ready_out;
      if (!ready_out && fifo_count == 3'd4) saw_full = 1'b1;
      tick(1'b0, 1'b1, src[idx]);
      if (rdy_now) idx++;
      guard++;
    end
    check_eq("t3_all_taken", 32'(idx), 32'd6);
    check_eq("t3_full_seen", 32'(saw_full), 32'd1);
    idle_ticks(70);
    check_words("t3_word", src);

    // 4: a word without valid is not taken
    restart();
    tick(1'b0, 1'b1, 8'hFF);
    tick(1'b0, 1'b1, 8'hEE);
    tick(1'b0, 1'b0, 8'hAA);
    tick(1'b0, 1'b1, 8'hCC);
    tick(1'b0, 1'b1, 8'hBB);
    idle_ticks(50);
    exp_w = '{8'hFF, 8'hEE, 8'hCC, 8'hBB};
    check_words("t4_word", exp_w);

    // 5: reset in the middle of a data word with two queued
    restart();
    tick(1'b0, 1'b1, 8'hCC);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (sending_data && word_start) found = 1'b1;
      else tick(1'b0, 1'b0, 8'h00);
    end
    check_eq("t5_cc_started", 32'(found), 32'd1);
    check_eq("t5_queued", 32'(fifo_count), 32'd2);
    idle_ticks(3);
    tick(1'b1, 1'b0, 8'h00);
    check_eq("t5_rst_dout", 32'(data_out), 32'd0);
    check_eq("t5_rst_count", 32'(fifo_count), 32'd0);
    tick(1'b0, 1'b0, 8'h00);
    dut_words.delete();
    idle_ticks(40);
    check_eq("t5_none_after", 32'(dut_words.size()), 32'd0);

    // 6: 10-bit, LSB first, custom idle word
    idle10 = 10'h17C;
    t6_bits = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    tick(1'b0, 1'b0, 8'h00);
    check_eq("t6_rst_ready", 32'(ready10), 32'd0);
    rst10 = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 30; k++) begin
      if (k < 20) check_eq("t6_train_bit", 32'(dout10), 32'(idle10[k % 10]));
      else        check_eq("t6_data_bit",  32'(dout10), 32'(t6_bits[k-20]));
      check_eq("t6_sending", 32'(sd10), 32'(k >= 20));
      check_eq("t6_wstart",  32'(ws10), 32'((k % 10) == 0));
      valid10 = (k == 0);
      data10  = 10'h2A5;
      tick(1'b0, 1'b0, 8'h00);
    end
    valid10 = 1'b0;
    rst10 = 1'b1;

    // random traffic with occasional reset, source holds until accepted
    restart();
    pend = 1'b0; pdata = '0;
    for (int i = 0; i < 500; i++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1'b1; pdata = 8'($urandom());
      end
      r = ($urandom_range(0, 79) == 0);
      rdy_now = ready_out;
      tick(r, pend, pdata);
      if (pend && rdy_now && !r) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
